// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: fetch FSM states, main-decoder
// opcodes and the default reset vector.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] sext_imm16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory request/ack bus and the decode-side
// valid/ready bus of the fetch unit. master = fetch unit, slave = environment.
interface instr_fetch_if;
  import mips_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic [31:0] instret;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr, op, instr_valid,
    input  instr_ready, jump, branch, zero,
    output pc, pcplus4, instret
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr, op, instr_valid,
    output instr_ready, jump, branch, zero,
    input  pc, pcplus4, instret
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection: jump target over taken branch over sequential PC.
module fetch_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic        zero_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pcplus4_o
);

  logic [31:0] branch_target;

  // NOTE: every output gets a default first so the block can never infer a latch.
  always_comb begin
    pcplus4_o     = pc_i + 32'd4;
    branch_target = pcplus4_o + (sext_imm16(instr_i[15:0]) << 2);
    next_pc_o     = pcplus4_o;
    if (jump_i) begin
      next_pc_o = {pcplus4_o[31:28], instr_i[25:0], 2'b00};
    end else if (branch_i && zero_i) begin
      next_pc_o = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Single-issue fetch unit: owns the PC, fetches over imem req/ack and presents
// each instruction to decode with valid/ready. All outputs come from registers.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  instret_q;
  logic         imem_req_q;
  logic         instr_valid_q;
  logic [31:0]  next_pc_d;
  logic [31:0]  pcplus4;

  fetch_next_pc u_next_pc (
    .pc_i      (pc_q),
    .instr_i   (instr_q),
    .jump_i    (bus.jump),
    .branch_i  (bus.branch),
    .zero_i    (bus.zero),
    .next_pc_o (next_pc_d),
    .pcplus4_o (pcplus4)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instret_q     <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            instr_q       <= bus.imem_rdata;
            state_q       <= HOLD;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          // Decoder controls only matter on the acceptance edge.
          if (bus.instr_ready) begin
            pc_q          <= next_pc_d;
            instret_q     <= instret_q + 32'd1;
            state_q       <= FETCH;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:26];
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.pcplus4     = pcplus4;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, branches, jumps, stalls,
// PC wrap and asynchronous reset, with hand-computed expected values.
module tb_instr_fetch;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] exp_instret;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in FETCH; returns in HOLD.
  task automatic fetch_instr(input logic [31:0] word, input logic [31:0] exp_pc);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    check("valid_after_ack", {31'b0, bus.instr_valid}, 32'd1);
    check("req_after_ack",   {31'b0, bus.imem_req},    32'd0);
    check("instr",           bus.instr,                word);
    check("op",              {26'b0, bus.op},          {26'b0, word[31:26]});
    check("pc_hold",         bus.pc,                   exp_pc);
    check("pcplus4",         bus.pcplus4,              exp_pc + 32'd4);
  endtask

  // Called in HOLD; returns in FETCH at the new PC.
  task automatic accept(input logic j, input logic b, input logic z, input logic [31:0] exp_next);
    bus.instr_ready = 1'b1;
    bus.jump        = j;
    bus.branch      = b;
    bus.zero        = z;
    step();
    bus.instr_ready = 1'b0;
    bus.jump        = 1'b0;
    bus.branch      = 1'b0;
    bus.zero        = 1'b0;
    exp_instret++;
    check("req_after_accept",   {31'b0, bus.imem_req},    32'd1);
    check("next_imem_addr",     bus.imem_addr,            exp_next);
    check("valid_after_accept", {31'b0, bus.instr_valid}, 32'd0);
    check("instret",            bus.instret,              exp_instret);
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    exp_instret     = '0;
    reset           = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.jump        = 1'b0;
    bus.branch      = 1'b0;
    bus.zero        = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_req",     {31'b0, bus.imem_req},    32'd0);
    check("rst_pc",      bus.pc,                   32'h0);
    check("rst_instr",   bus.instr,                32'h0);
    check("rst_valid",   {31'b0, bus.instr_valid}, 32'd0);
    check("rst_instret", bus.instret,              32'h0);

    reset = 1'b0;
    step();
    check("first_req",  {31'b0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr,         32'h0);

    // Back-to-back ADDI stream at 0x0, 0x4, 0x8.
    for (int i = 0; i < 3; i++) begin
      fetch_instr(32'h2008_0005, 32'(i * 4));
      accept(1'b0, 1'b0, 1'b0, 32'((i + 1) * 4));
    end
    check("instret_three", bus.instret, 32'd3);

    // Branch cases at 0x10, returning there with J 0x10.
    fetch_instr(32'h0800_0004, 32'h0000_000C);
    accept(1'b1, 1'b0, 1'b0, 32'h0000_0010);
    fetch_instr(32'h1000_0003, 32'h0000_0010);
    accept(1'b0, 1'b1, 1'b1, 32'h0000_0020);
    fetch_instr(32'h0800_0004, 32'h0000_0020);
    accept(1'b1, 1'b0, 1'b0, 32'h0000_0010);
    fetch_instr(32'h1000_0003, 32'h0000_0010);
    accept(1'b0, 1'b1, 1'b0, 32'h0000_0014);
    fetch_instr(32'h0800_0004, 32'h0000_0014);
    accept(1'b1, 1'b0, 1'b0, 32'h0000_0010);
    fetch_instr(32'h1000_FFFF, 32'h0000_0010);
    accept(1'b0, 1'b1, 1'b1, 32'h0000_0010);
    // Backward branch below zero: 0x14 - 0x28.
    fetch_instr(32'h1000_FFF6, 32'h0000_0010);
    accept(1'b0, 1'b1, 1'b1, 32'hFFFF_FFEC);

    // Ack delayed three cycles.
    for (int k = 0; k < 3; k++) begin
      bus.imem_rdata = 32'(k) ^ 32'h5555_0000;
      check("wait_req",   {31'b0, bus.imem_req},    32'd1);
      check("wait_addr",  bus.imem_addr,            32'hFFFF_FFEC);
      check("wait_valid", {31'b0, bus.instr_valid}, 32'd0);
      step();
    end
    check("wait_req_last",  {31'b0, bus.imem_req},    32'd1);
    check("wait_addr_last", bus.imem_addr,            32'hFFFF_FFEC);
    check("wait_valid_last", {31'b0, bus.instr_valid}, 32'd0);

    // Jump keeps the upper nibble of pc+4.
    fetch_instr(32'h0800_0040, 32'hFFFF_FFEC);
    accept(1'b1, 1'b0, 1'b0, 32'hF000_0100);

    // Stray ack in HOLD, then jump wins over a taken branch.
    fetch_instr(32'h0BFF_FFFF, 32'hF000_0100);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    step();
    bus.imem_ack   = 1'b0;
    check("stray_instr", bus.instr,                32'h0BFF_FFFF);
    check("stray_valid", {31'b0, bus.instr_valid}, 32'd1);
    check("stray_req",   {31'b0, bus.imem_req},    32'd0);
    check("stray_pc",    bus.pc,                   32'hF000_0100);
    accept(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);

    // Five stall cycles at the top of memory, then wrap to zero.
    fetch_instr(32'h2008_0005, 32'hFFFF_FFFC);
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_instr",   bus.instr,                32'h2008_0005);
      check("stall_pc",      bus.pc,                   32'hFFFF_FFFC);
      check("stall_instret", bus.instret,              exp_instret);
      check("stall_req",     {31'b0, bus.imem_req},    32'd0);
      check("stall_valid",   {31'b0, bus.instr_valid}, 32'd1);
    end
    accept(1'b0, 1'b0, 1'b0, 32'h0000_0000);
    fetch_instr(32'h2008_0005, 32'h0000_0000);
    accept(1'b0, 1'b0, 1'b0, 32'h0000_0004);

    // Reset in the middle of an outstanding request, between clock edges.
    step();
    #2 reset = 1'b1;
    #1;
    exp_instret = '0;
    check("async_req",     {31'b0, bus.imem_req},    32'd0);
    check("async_pc",      bus.pc,                   32'h0);
    check("async_valid",   {31'b0, bus.instr_valid}, 32'd0);
    check("async_instret", bus.instret,              32'h0);
    @(negedge clk);
    check("held_req", {31'b0, bus.imem_req}, 32'd0);
    reset = 1'b0;
    step();
    check("restart_req",  {31'b0, bus.imem_req}, 32'd1);
    check("restart_addr", bus.imem_addr,         32'h0);
    fetch_instr(32'h2008_0005, 32'h0000_0000);
    accept(1'b0, 1'b0, 1'b0, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
